// File: rtl/capture_sequencer_if.sv
// Stream interface between the ADC sampler, the capture sequencer and the
// downstream processing chain.
//
//   adc_data        unsigned ADC sample
//   adc_data_valid  one-cycle strobe qualifying adc_data
//   smp_data        signed, offset-removed sample
//   smp_valid       smp_data is valid
//   smp_ready       downstream accepts smp_data
//   smp_last        smp_data is the last sample of its frame
//   frame_idx       frame index of smp_data
//
// The master modport is the sequencer side: it consumes the ADC stream and
// sources the sample stream. The slave modport is the environment side.
interface capture_sequencer_if #(
  parameter int DATA_W = 12,
  parameter int IDX_W  = 6
) ();

  logic        [DATA_W-1:0] adc_data;
  logic                     adc_data_valid;
  logic signed [DATA_W-1:0] smp_data;
  logic                     smp_valid;
  logic                     smp_ready;
  logic                     smp_last;
  logic        [IDX_W-1:0]  frame_idx;

  modport master (
    input  adc_data,
    input  adc_data_valid,
    input  smp_ready,
    output smp_data,
    output smp_valid,
    output smp_last,
    output frame_idx
  );

  modport slave (
    output adc_data,
    output adc_data_valid,
    output smp_ready,
    input  smp_data,
    input  smp_valid,
    input  smp_last,
    input  frame_idx
  );

endinterface

// File: rtl/capture_sequencer.sv
// Capture sequencer: runs one recording pass between the ADC sampler and the
// processing chain. After start it keeps one of every DECIM valid ADC
// samples, removes the DC offset and presents the result on a valid/ready
// stream framed into NUM_FRAMES frames of FRAME_LEN samples.
//
// Ports:
//   clk      system clock
//   reset    asynchronous, active-low reset
//   start    single-cycle request to begin a pass (ignored while busy)
//   abort    single-cycle request to cancel a pass (ignored when idle)
//   stream   master side of capture_sequencer_if (ADC in, samples out)
//   busy     high in every state except IDLE
//   done     one-cycle pulse when a pass completes
//   overrun  sticky: a kept sample was dropped because of backpressure
module capture_sequencer #(
  parameter int DATA_W     = 12,
  parameter int FRAME_LEN  = 1024,
  parameter int NUM_FRAMES = 64,
  parameter int DECIM      = 4,
  parameter int DC_OFFSET  = 2048
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  capture_sequencer_if.master stream,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  localparam int SMP_W = $clog2(FRAME_LEN);
  localparam int IDX_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DEC_W-1:0] dec_cnt;
  logic [SMP_W-1:0] smp_cnt;
  logic [IDX_W-1:0] frm_cnt;

  logic signed [DATA_W-1:0] smp_data_p1;
  logic                     vld_p1;
  logic                     last_p1;
  logic        [IDX_W-1:0]  frm_p1;

  logic begin_pass;
  logic kill;
  logic adc_in;
  logic keep;
  logic load;
  logic drop;
  logic take;
  logic last_smp;
  logic last_frm;

  // Mod-2^DATA_W subtraction reinterpreted as two's complement, so mid-scale
  // maps to zero and the rails map to the signed extremes.
  function automatic logic signed [DATA_W-1:0] remove_offset(
    input logic [DATA_W-1:0] raw
  );
    logic [DATA_W-1:0] diff;
    diff = raw - DATA_W'(DC_OFFSET);
    return signed'(diff);
  endfunction

  assign take     = vld_p1 && stream.smp_ready;
  assign last_smp = (smp_cnt == SMP_W'(FRAME_LEN - 1));
  assign last_frm = (frm_cnt == IDX_W'(NUM_FRAMES - 1));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    begin_pass = 1'b0;
    kill       = 1'b0;
    adc_in     = 1'b0;
    keep       = 1'b0;
    load       = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt  = CAPTURE;
          begin_pass = 1'b1;
        end
      end
      CAPTURE: begin
        if (abort) begin
          kill      = 1'b1;
          state_nxt = IDLE;
        end else begin
          adc_in = stream.adc_data_valid;
          keep   = adc_in && (dec_cnt == '0);
          // The output register can take a new sample when it is empty or
          // is being emptied by downstream in this same cycle.
          load   = keep && (!vld_p1 || stream.smp_ready);
          drop   = keep && vld_p1 && !stream.smp_ready;
          if (load && last_smp && last_frm) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          kill      = 1'b1;
          state_nxt = IDLE;
        end else if (take) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        kill      = abort;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Stage p0: decimation phase, sample position and frame position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_cnt <= '0;
      smp_cnt <= '0;
      frm_cnt <= '0;
      overrun <= 1'b0;
    end else if (begin_pass) begin
      dec_cnt <= '0;
      smp_cnt <= '0;
      frm_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      if (adc_in) begin
        dec_cnt <= (dec_cnt == DEC_W'(DECIM - 1)) ? '0 : dec_cnt + DEC_W'(1);
      end
      if (load) begin
        if (last_smp) begin
          smp_cnt <= '0;
          frm_cnt <= frm_cnt + IDX_W'(1);
        end else begin
          smp_cnt <= smp_cnt + SMP_W'(1);
        end
      end
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

  // Stage p1: output register, held stable while downstream stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      smp_data_p1 <= '0;
      vld_p1      <= 1'b0;
      last_p1     <= 1'b0;
      frm_p1      <= '0;
    end else if (kill) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (load) begin
      smp_data_p1 <= remove_offset(stream.adc_data);
      vld_p1      <= 1'b1;
      last_p1     <= last_smp;
      frm_p1      <= frm_cnt;
    end else if (take) begin
      vld_p1 <= 1'b0;
    end
  end

  // The completion pulse is registered out of DONE so that an abort arriving
  // while in DONE can still suppress it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done <= 1'b0;
    end else begin
      done <= (state == DONE) && !abort;
    end
  end

  assign stream.smp_data  = smp_data_p1;
  assign stream.smp_valid = vld_p1;
  assign stream.smp_last  = last_p1;
  assign stream.frame_idx = frm_p1;

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Sequences one recording pass between the ADC sampler and the shazam processing chain.
- On `start`, it gates the `adc_data`/`adc_data_valid` stream, decimates it and removes the DC offset.
- It frames the samples into NUM_FRAMES frames of FRAME_LEN samples, presented on a valid/ready stream with a frame-last marker.
- It reports busy, done, frame index and a sticky overrun flag when downstream backpressure drops samples.

Parameters:
- DATA_W, 12, ADC sample width.
- FRAME_LEN, 1024, samples per frame after decimation; power of two, at least 2.
- NUM_FRAMES, 64, frames per recording pass; at least 1.
- DECIM, 4, keep 1 of every DECIM valid ADC samples; at least 1.
- DC_OFFSET, 2048, unsigned mid-scale value subtracted from each sample.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a pass.
- abort  in  1  single-cycle request to cancel a pass.
- adc_data  in  DATA_W  unsigned ADC sample.
- adc_data_valid  in  1  one-cycle strobe; adc_data is valid this cycle.
- smp_data  out  DATA_W  signed, offset-removed sample.
- smp_valid  out  1  smp_data is valid.
- smp_ready  in  1  downstream accepts smp_data.
- smp_last  out  1  smp_data is the last sample of its frame.
- frame_idx  out  clog2(NUM_FRAMES)  index of the frame of smp_data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a pass completes.
- overrun  out  1  sticky flag: at least one sample was dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - smp_data, smp_valid, smp_last, frame_idx, busy, done and overrun all 0.
  - Decimation counter, sample counter and frame counter all 0.
- States: IDLE, CAPTURE, DRAIN, DONE.
- IDLE:
  - start=1 and abort=0 -> CAPTURE.
  - On that transition, clear overrun and all counters.
  - start and abort both high in IDLE -> remain in IDLE.
- CAPTURE, decimation:
  - On each adc_data_valid, the decimation counter wraps 0..DECIM-1.
  - The sample is a candidate when the counter is 0, so the first valid after entry is kept.
  - adc_data_valid is ignored in IDLE, DRAIN and DONE.
- Conversion:
  - smp_data = (adc_data - DC_OFFSET) mod 2^DATA_W, interpreted as two's complement.
  - Example: 2048 -> 0, 0 -> -2048, 4095 -> +2047.
- Output register load, candidate accepted (smp_valid=0 or smp_ready=1 in the same cycle):
  - Load smp_data and set smp_valid=1.
  - smp_last=1 if the sample counter is FRAME_LEN-1.
  - frame_idx = frame counter.
  - Advance the sample counter; on wrap, advance the frame counter.
- Output register load, candidate dropped (smp_valid=1 and smp_ready=0):
  - Discard the candidate and set overrun=1.
  - Counters do not advance.
  - The held output is unchanged.
- Output handshake:
  - smp_valid and smp_ready both high with no new load -> smp_valid=0 next cycle.
  - smp_data, smp_last and frame_idx are held stable while smp_valid=1 and smp_ready=0.
  - Throughput is one sample per cycle; latency from adc_data_valid to smp_valid is 1 cycle.
- Loading the last sample (last frame, last sample) -> DRAIN.
- DRAIN: on smp_valid and smp_ready both high -> DONE.
- DONE: done=1 for exactly one cycle, then IDLE. overrun is retained until the next start.
- abort=1 in CAPTURE, DRAIN or DONE:
  - Next state is IDLE with smp_valid=0 and smp_last=0.
  - done is not pulsed; abort in DONE suppresses the pulse.
  - overrun is retained.
- start while busy is ignored.
- abort in IDLE is ignored.

Test Plan:
- Reset and ignore-when-idle: assert reset low mid-pass -> all outputs 0 immediately, state IDLE; drive adc_data_valid in IDLE -> smp_valid stays 0.
- Full pass, FRAME_LEN=4, NUM_FRAMES=2, DECIM=1, smp_ready=1:
  - Stimulus: start, then 8 valids of adc_data 2048,2049,...,2055.
  - Required: smp_data 0..7, each 1 cycle after its valid.
  - Required: smp_last on the 4th and 8th samples; frame_idx 0,0,0,0,1,1,1,1.
  - Required: done pulses once, 2 cycles after the 8th sample is accepted; busy=0 thereafter.
- Decimation and arithmetic, DECIM=4:
  - Stimulus: valids carrying 0, 100, 200, 300, 4095.
  - Required: outputs -2048 (from 0) and +2047 (from 4095); the other three are never output.
- Backpressure:
  - Stimulus: hold smp_ready=0 while two kept samples arrive.
  - Required: the first is held stable, the second is dropped and overrun=1.
  - Required: counters do not advance on the drop; the pass still needs the full sample count before done.
- Abort mid-pass:
  - Stimulus: abort during frame 1 of CAPTURE.
  - Required: IDLE next cycle, smp_valid=0, no done pulse.
  - Required: a subsequent start runs a complete pass from frame_idx 0 with overrun cleared.
- Simultaneous and late events:
  - start and abort together in IDLE -> stays IDLE.
  - start during CAPTURE -> ignored, counters unchanged.
  - smp_ready withheld in DRAIN -> state holds, done only after the handshake.
